// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision divider: field widths, bias,
// canonical special-value encodings and the controller state type.
package fp_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;
  localparam int          BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] INF_MAG = 31'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    NORMALIZE,
    DONE
  } state_e;

endpackage

// File: rtl/fp_classify.sv
// Operand classifier: zero (denormals flushed) and inf/NaN detection from the
// biased exponent alone.
module fp_classify
  import fp_pkg::*;
(
  input  logic [EXP_W-1:0] exp_i,
  output logic             is_zero_o,
  output logic             is_inf_nan_o
);

  assign is_zero_o    = (exp_i == '0);
  assign is_inf_nan_o = (exp_i == '1);

endmodule

// File: rtl/fp_divide.sv
// IEEE-754 single-precision divider, restoring mantissa division, 1 bit/cycle.
// Define FP_DIV_ROUND_NEAREST_EN for round-to-nearest-even; default truncates.
module fp_divide
  import fp_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        valid_o,
  output logic [31:0] quotient_o,
  output logic        dz_o
);

  localparam int unsigned QW = 26;

  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [QW-1:0]      rem_q, rem_d;
  logic [QW-1:0]      q_q, q_d;
  logic [MANT_W:0]    divisor_q, divisor_d;
  logic signed [9:0]  exp_q, exp_d;
  logic               sign_q, sign_d;
  logic [31:0]        quotient_q, quotient_d;
  logic               dz_q, dz_d;

  logic a_zero, a_inf_nan, b_zero, b_inf_nan;
  logic [QW-1:0]      rem_sub;
  logic [MANT_W-1:0]  mant, mant_f;
  logic signed [9:0]  exp_n, exp_r;
`ifdef FP_DIV_ROUND_NEAREST_EN
  logic               guard, sticky, round_up;
  logic [MANT_W:0]    mant_r;
`endif

  fp_classify u_cls_a (
    .exp_i        (a_i[30:23]),
    .is_zero_o    (a_zero),
    .is_inf_nan_o (a_inf_nan)
  );

  fp_classify u_cls_b (
    .exp_i        (b_i[30:23]),
    .is_zero_o    (b_zero),
    .is_inf_nan_o (b_inf_nan)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    q_d        = q_q;
    divisor_d  = divisor_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    quotient_d = quotient_q;
    dz_d       = dz_q;
    rem_sub    = rem_q;
    mant       = q_q[25] ? q_q[24:2] : q_q[23:1];
    exp_n      = q_q[25] ? exp_q : exp_q - 10'sd1;
`ifdef FP_DIV_ROUND_NEAREST_EN
    guard    = q_q[25] ? q_q[1] : q_q[0];
    sticky   = (q_q[25] & q_q[0]) | (rem_q != '0);
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + 24'(round_up);
    // An all-ones mantissa rounding up wraps to zero and carries into the exponent.
    mant_f   = mant_r[MANT_W-1:0];
    exp_r    = exp_n + $signed({9'b0, mant_r[MANT_W]});
`else
    mant_f   = mant;
    exp_r    = exp_n;
`endif

    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          sign_d    = a_i[31] ^ b_i[31];
          exp_d     = {2'b00, a_i[30:23]} - {2'b00, b_i[30:23]} + 10'(BIAS);
          rem_d     = {2'b00, 1'b1, a_i[22:0]};
          divisor_d = {1'b1, b_i[22:0]};
          q_d       = '0;
          cnt_d     = '0;
          state_d   = DONE;
          if (a_inf_nan || b_inf_nan || (a_zero && b_zero)) begin
            quotient_d = QNAN;
            dz_d       = 1'b0;
          end else if (b_zero) begin
            quotient_d = {a_i[31] ^ b_i[31], INF_MAG};
            dz_d       = 1'b1;
          end else if (a_zero) begin
            quotient_d = {a_i[31] ^ b_i[31], 31'b0};
            dz_d       = 1'b0;
          end else begin
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        if (rem_q >= {2'b00, divisor_q}) begin
          rem_sub = rem_q - {2'b00, divisor_q};
          q_d     = {q_q[QW-2:0], 1'b1};
        end else begin
          q_d     = {q_q[QW-2:0], 1'b0};
        end
        rem_d = rem_sub << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(QW - 1)) state_d = NORMALIZE;
      end
      NORMALIZE: begin
        dz_d    = 1'b0;
        state_d = DONE;
        if (exp_r >= 10'sd255)    quotient_d = {sign_q, INF_MAG};
        else if (exp_r <= 10'sd0) quotient_d = {sign_q, 31'b0};
        else                      quotient_d = {sign_q, exp_r[7:0], mant_f};
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      q_q        <= '0;
      divisor_q  <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      quotient_q <= '0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      q_q        <= q_d;
      divisor_q  <= divisor_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      quotient_q <= quotient_d;
      dz_q       <= dz_d;
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign valid_o    = (state_q == DONE);
  assign quotient_o = quotient_q;
  assign dz_o       = dz_q;

endmodule

// File: tb/tb_fp_divide.sv
// Scoreboard bench for fp_divide: driver pushes expected results on accept,
// a negedge monitor pops and checks quotient, dz and latency on valid_o.
module tb_fp_divide;

  logic        clk = 1'b0;
  logic        reset_i, valid_i, ready_o, valid_o, dz_o;
  logic [31:0] a_i, b_i, quotient_o;

  localparam logic [31:0] ONE_THIRD =
`ifdef FP_DIV_ROUND_NEAREST_EN
    32'h3EAA_AAAB;
`else
    32'h3EAA_AAAA;
`endif

  typedef struct {
    logic [31:0] q;
    logic        dz;
    int unsigned due;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  fp_divide dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .a_i        (a_i),
    .b_i        (b_i),
    .valid_o    (valid_o),
    .quotient_o (quotient_o),
    .dz_o       (dz_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_i && valid_o) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got valid_o=1 at cycle %0d want no result pending", cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_q"}, quotient_o, mon_e.q);
        check({mon_e.name, "_dz"}, {31'b0, dz_o}, {31'b0, mon_e.dz});
        check({mon_e.name, "_lat"}, cyc, mon_e.due);
      end
    end
  end

  // Leaves valid_i high after accept when keep=1 so the next call continues back-to-back.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                      input logic dz, input int unsigned lat, input string nm,
                      input bit push, input bit keep);
    exp_t e;
    bit   acc = 0;
    @(negedge clk);
    a_i = a; b_i = b; valid_i = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      if (ready_o) begin
        if (push) begin
          e.q = q; e.dz = dz; e.due = cyc + lat; e.name = nm;
          sb.push_back(e);
        end
        acc = 1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL %s_accept: got no ready_o within 200 cycles want accept", nm);
    end
    if (!keep) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_ready"},  {31'b0, ready_o}, 32'd1);
    check({nm, "_valid"},  {31'b0, valid_o}, 32'd0);
    check({nm, "_quot"},   quotient_o,       32'd0);
    check({nm, "_dz"},     {31'b0, dz_o},    32'd0);
  endtask

  initial begin
    reset_i = 1'b1; valid_i = 1'b0; a_i = '0; b_i = '0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    reset_i = 1'b0;

    send(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 28, "six_by_two",  1, 0);
    send(32'h3F80_0000, 32'h4040_0000, ONE_THIRD,     1'b0, 28, "one_third",   1, 0);
    send(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1, 1,  "neg_by_zero", 1, 0);
    send(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b0, 28, "overflow",    1, 0);
    send(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 28, "underflow",   1, 0);
    send(32'h3F90_0000, 32'h3FC0_0000, 32'h3F40_0000, 1'b0, 28, "norm_shift",  1, 0);
    send(32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1,  "inf_a",       1, 0);
    send(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1,  "zero_zero",   1, 0);
    send(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1,  "negzero_a",   1, 0);
    send(32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000, 1'b0, 28, "neg_one",     1, 0);
    send(32'h7FC0_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1,  "nan_by_zero", 1, 0);
    drain();

    // Abandoned division: accepted but never expected on the output.
    send(32'h40C0_0000, 32'h4000_0000, 32'h0, 1'b0, 28, "aborted", 0, 0);
    repeat (8) @(negedge clk);
    reset_i = 1'b1;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    reset_i = 1'b0;
    send(32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 28, "after_reset", 1, 0);
    drain();

    send(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 28, "b2b_0", 1, 1);
    send(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1,  "b2b_1", 1, 1);
    send(32'h3FC0_0000, 32'h4000_0000, 32'h3F40_0000, 1'b0, 28, "b2b_2", 1, 0);
    drain();
    repeat (30) @(negedge clk);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_divide.md
FP_DIVIDE -- requirements
Module: fp_divide

Interface
REQ-001 SHALL have a single clock domain; reset is asynchronous and active-high.
REQ-002 SHALL provide port clk_i  input  1  clock, rising-edge active.
REQ-003 SHALL provide port reset_i  input  1  asynchronous active-high reset.
REQ-004 SHALL provide port valid_i  input  1  operands present.
REQ-005 SHALL provide port ready_o  output  1  block can accept operands; high only in IDLE.
REQ-006 SHALL provide port a_i  input  32  IEEE-754 single dividend.
REQ-007 SHALL provide port b_i  input  32  IEEE-754 single divisor.
REQ-008 SHALL provide port valid_o  output  1  one-cycle result strobe.
REQ-009 SHALL provide port quotient_o  output  32  a/b result, held until next accept.
REQ-010 SHALL provide port dz_o  output  1  divide-by-zero flag, same timing as quotient_o.

Function
REQ-011 SHALL accept (latch a_i, b_i) on the rising edge where valid_i=1 and ready_o=1; valid_i while busy is ignored.
REQ-012 SHALL implement states IDLE, DIVIDE, NORMALIZE, DONE; DONE returns to IDLE after one cycle.
REQ-013 SHALL classify operands: exponent 0 is zero (denormals flushed); exponent 255 is inf/NaN.
REQ-014 SHALL, for a special case, go IDLE->DONE directly; valid_o high 1 cycle after accept.
REQ-015 SHALL output 0x7FC00000 when either operand is inf/NaN, or both are zero; dz_o=0.
REQ-016 SHALL output sign|0x7F800000 and dz_o=1 for finite nonzero a divided by zero b.
REQ-017 SHALL output signed zero for zero a with nonzero finite b; result sign is always sign_a XOR sign_b.
REQ-018 SHALL compute the mantissa by restoring division of {1,ma} by {1,mb}: one quotient bit per cycle, 26 DIVIDE cycles, yielding q[25:0] with q[25] weighted 2^0.
REQ-019 SHALL, in NORMALIZE with q[25]=1: mantissa=q[24:2], guard=q[1], sticky=q[0]|(rem!=0); with q[25]=0: mantissa=q[23:1], guard=q[0], sticky=(rem!=0), exponent decremented by 1.
REQ-020 SHALL compute the biased exponent in 10-bit signed arithmetic as ea-eb+127 (minus normalization adjust, plus rounding carry).
REQ-021 SHALL saturate exponent >=255 to signed infinity and exponent <=0 to signed zero.
REQ-022 SHALL assert valid_o for exactly one cycle in DONE; normal-path latency is 28 cycles from accept (26 DIVIDE + 1 NORMALIZE + DONE).
REQ-023 SHALL hold quotient_o and dz_o stable from valid_o until the next result is written.

Reset
REQ-024 SHALL on reset_i force state IDLE, ready_o=1, valid_o=0, quotient_o=0, dz_o=0, quotient/remainder registers 0.
REQ-025 SHALL abandon any in-flight division on reset; no valid_o is produced for it.

Configuration
REQ-026 SHALL honour macro FP_DIV_ROUND_NEAREST_EN: defined -> round-to-nearest-even using guard/sticky/LSB; undefined -> truncation (guard and sticky ignored), no rounding adder synthesized.

Structure
REQ-027 SHALL place the state enum, field widths (8 exp, 23 mant), bias 127 and the canonical NaN/inf constants in shared package fp_pkg.
REQ-028 SHALL implement the special-case classifier as sub-module fp_classify (one instance per operand: is_zero, is_inf_nan).

Verification
REQ-029 SHALL cover 0x40C00000 / 0x40000000 (6/2) -> 0x40400000, dz_o=0, valid_o 28 cycles after accept.
REQ-030 SHALL cover 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB with macro, 0x3EAAAAAA without.
REQ-031 SHALL cover 0xBF800000 / 0x00000000 -> 0xFF800000, dz_o=1, valid_o 1 cycle after accept.
REQ-032 SHALL cover 0x7F000000 / 0x3E800000 -> 0x7F800000 (overflow); 0x00800000 / 0x40000000 -> 0x00000000 (underflow flush).
REQ-033 SHALL cover reset_i pulsed mid-DIVIDE (cycle 10) -> outputs at reset values, no valid_o, next 0x40000000/0x3F800000 -> 0x40000000.
REQ-034 SHALL cover valid_i held high throughout -> back-to-back accepts only when ready_o=1, one valid_o per accepted pair.
